// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial adder.
//   - state_t   : FSM state encoding (IDLE, RUN, DONE)
//   - MODE_*    : operation mode encodings for the 'sub' input
//   - cnt_width : bit counter width for a given operand width
package bit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

  // $clog2(w), but never narrower than one bit so WIDTH=1 still has a counter.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/bit_serial_adder_if.sv
// Request/response bundle for the bit-serial adder.
//   Requester -> adder : start, sub, a_in, b_in
//   Adder -> requester : busy, done, sum, cout, ovf, dbg_state
// Handshake: 'start' is sampled only while the adder is idle or in its done
// cycle; an accepted start raises 'busy' from the next cycle until the
// completion edge, after which 'done' pulses for exactly one cycle and
// sum/cout/ovf are valid and held until the next completion. 'start' seen
// while busy is dropped, not queued.
interface bit_serial_adder_if
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  state_t           dbg_state;

  modport master (
    output start, sub, a_in, b_in,
    input  busy, done, sum, cout, ovf, dbg_state
  );

  modport slave (
    input  start, sub, a_in, b_in,
    output busy, done, sum, cout, ovf, dbg_state
  );

endinterface

// File: rtl/bit_serial_adder_full_adder_cell.sv
// Combinational one-bit full adder used as the whole datapath of the
// bit-serial adder.
//   a_i, b_i, cin_i : operand bits and carry in
//   s_o             : sum bit  (a ^ b ^ cin)
//   co_o            : carry out (majority of a, b, cin)
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ cin_i;
  assign co_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder/subtractor: one operand bit per clock, LSB first, through
// a single full-adder cell and a registered carry.
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of bit_serial_adder_if (start/sub/a_in/b_in in;
//           busy/done/sum/cout/ovf/dbg_state out)
// Latency start->done is WIDTH cycles; with start held high a new operation
// is accepted in the DONE cycle, giving one result per WIDTH+1 cycles.
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  bit_serial_adder_if.slave  bus
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;

  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   res_d;
  logic               sub_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;

  logic               load;
  logic               step;
  logic               last;

  logic               fa_s;
  logic               fa_co;

  // Subtraction is a + ~b + 1: b is inverted bit by bit here and the +1 comes
  // from preloading the carry register with 'sub'.
  full_adder_cell u_cell (
    .a_i   (a_sh_q[0]),
    .b_i   (b_sh_q[0] ^ sub_q),
    .cin_i (carry_q),
    .s_o   (fa_s),
    .co_o  (fa_co)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == LAST_CNT) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // Back-to-back: a start seen in the done cycle is taken immediately.
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  // New sum bit enters at the MSB so that after WIDTH steps the register
  // holds the result in natural bit order. Written as shift-then-overwrite so
  // it stays legal for WIDTH=1.
  always_comb begin
    res_d            = res_q >> 1;
    res_d[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (load) begin
      a_sh_q  <= bus.a_in;
      b_sh_q  <= bus.b_in;
      res_q   <= '0;
      sub_q   <= bus.sub;
      carry_q <= bus.sub;
      cnt_q   <= '0;
    end else if (step) begin
      a_sh_q  <= a_sh_q >> 1;
      b_sh_q  <= b_sh_q >> 1;
      res_q   <= res_d;
      carry_q <= fa_co;
      cnt_q   <= cnt_q + CNT_W'(1);
      // Only the completion edge touches the visible results; on that cycle
      // carry_q is the carry into the MSB and fa_co the carry out of it.
      if (last) begin
        sum_q  <= res_d;
        cout_q <= fa_co;
        ovf_q  <= carry_q ^ fa_co;
      end
    end
  end

  // ------------------------------------------------------------ outputs
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder at WIDTH = 8, 1 and 32.
module tb_bit_serial_adder;
  import bit_serial_pkg::*;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  bit_serial_adder_if #(.WIDTH(8))  bus8  ();
  bit_serial_adder_if #(.WIDTH(1))  bus1  ();
  bit_serial_adder_if #(.WIDTH(32)) bus32 ();

  bit_serial_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  bit_serial_adder #(.WIDTH(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  bit_serial_adder #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  // ---------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      1:       return bus1.done;
      32:      return bus32.done;
      default: return bus8.done;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      1:       return bus1.busy;
      32:      return bus32.busy;
      default: return bus8.busy;
    endcase
  endfunction

  // Called at the sample point after the accepting edge; returns the number
  // of edges until done is seen (bounded by budget).
  task automatic wait_done(input int sel, input int budget,
                           output int cycles, output int busy_cnt, output int both_cnt);
    cycles   = 0;
    busy_cnt = 0;
    both_cnt = 0;
    while (!done_of(sel) && cycles < budget) begin
      if (busy_of(sel)) busy_cnt++;
      tick();
      cycles++;
      if (busy_of(sel) && done_of(sel)) both_cnt++;
    end
  endtask

  // Drive one request into the 8-bit instance and let the accepting edge pass.
  task automatic start8(input logic s, input logic [7:0] a, input logic [7:0] b);
    bus8.sub   = s;
    bus8.a_in  = a;
    bus8.b_in  = b;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
  endtask

  // ---------------------------------------------------------- stimulus
  initial begin
    int cyc;
    int bcnt;
    int both;
    int done_seen;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus8.start  = 1'b0; bus8.sub  = 1'b0; bus8.a_in  = '0; bus8.b_in  = '0;
    bus1.start  = 1'b0; bus1.sub  = 1'b0; bus1.a_in  = '0; bus1.b_in  = '0;
    bus32.start = 1'b0; bus32.sub = 1'b0; bus32.a_in = '0; bus32.b_in = '0;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state.
    chk("rst_busy8",  64'(bus8.busy), 64'd0);
    chk("rst_done8",  64'(bus8.done), 64'd0);
    chk("rst_sum8",   64'(bus8.sum),  64'd0);
    chk("rst_cout8",  64'(bus8.cout), 64'd0);
    chk("rst_ovf8",   64'(bus8.ovf),  64'd0);
    chk("rst_state8", 64'(bus8.dbg_state), 64'(IDLE));
    chk("rst_done1",  64'(bus1.done), 64'd0);
    chk("rst_sum32",  64'(bus32.sum), 64'd0);

    // 0x3A + 0x55 = 0x8F, signed 58+85 overflows.
    start8(MODE_ADD, 8'h3A, 8'h55);
    chk("add1_busy_after_e0", 64'(bus8.busy), 64'd1);
    wait_done(8, 64, cyc, bcnt, both);
    chk("add1_latency",   64'(cyc),  64'd8);
    chk("add1_busy_cyc",  64'(bcnt), 64'd8);
    chk("add1_busy_done", 64'(both), 64'd0);
    chk("add1_busy_at_done", 64'(bus8.busy), 64'd0);
    chk("add1_sum",  64'(bus8.sum),  64'h8F);
    chk("add1_cout", 64'(bus8.cout), 64'd0);
    chk("add1_ovf",  64'(bus8.ovf),  64'd1);
    tick();
    chk("add1_done_pulse", 64'(bus8.done), 64'd0);
    chk("add1_back_idle",  64'(bus8.dbg_state), 64'(IDLE));
    chk("add1_sum_hold",   64'(bus8.sum), 64'h8F);

    // 0xFF + 0x01 wraps with carry, no signed overflow.
    start8(MODE_ADD, 8'hFF, 8'h01);
    wait_done(8, 64, cyc, bcnt, both);
    chk("add2_latency", 64'(cyc), 64'd8);
    chk("add2_sum",  64'(bus8.sum),  64'h00);
    chk("add2_cout", 64'(bus8.cout), 64'd1);
    chk("add2_ovf",  64'(bus8.ovf),  64'd0);
    tick();

    // 0x80 - 0x01: -128-1 overflows to 0x7F, no borrow.
    start8(MODE_SUB, 8'h80, 8'h01);
    wait_done(8, 64, cyc, bcnt, both);
    chk("sub1_sum",  64'(bus8.sum),  64'h7F);
    chk("sub1_cout", 64'(bus8.cout), 64'd1);
    chk("sub1_ovf",  64'(bus8.ovf),  64'd1);
    tick();

    // 0x10 - 0x20 = 0xF0 with borrow; start then stays high for back-to-back.
    bus8.sub   = MODE_SUB;
    bus8.a_in  = 8'h10;
    bus8.b_in  = 8'h20;
    bus8.start = 1'b1;
    tick();
    wait_done(8, 64, cyc, bcnt, both);
    chk("sub2_sum",  64'(bus8.sum),  64'hF0);
    chk("sub2_cout", 64'(bus8.cout), 64'd0);
    chk("sub2_ovf",  64'(bus8.ovf),  64'd0);
    // Next request (0x0F + 0x01) is taken in the done cycle.
    bus8.sub  = MODE_ADD;
    bus8.a_in = 8'h0F;
    bus8.b_in = 8'h01;
    tick();
    chk("b2b_accept_busy", 64'(bus8.busy), 64'd1);
    chk("b2b_sum_hold",    64'(bus8.sum),  64'hF0);
    wait_done(8, 64, cyc, bcnt, both);
    chk("b2b_period", 64'(cyc + 1), 64'd9);
    chk("b2b_sum",  64'(bus8.sum),  64'h10);
    chk("b2b_cout", 64'(bus8.cout), 64'd0);
    chk("b2b_ovf",  64'(bus8.ovf),  64'd0);
    bus8.start = 1'b0;
    tick();
    chk("b2b_idle", 64'(bus8.dbg_state), 64'(IDLE));

    // Start pulsed mid-RUN with different operands must be ignored.
    start8(MODE_ADD, 8'h3A, 8'h55);
    repeat (3) tick();
    bus8.sub   = MODE_SUB;
    bus8.a_in  = 8'hFF;
    bus8.b_in  = 8'hFF;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    chk("pulse_sum_hold", 64'(bus8.sum), 64'h10);
    chk("pulse_no_done",  64'(bus8.done), 64'd0);
    wait_done(8, 64, cyc, bcnt, both);
    chk("pulse_latency", 64'(cyc), 64'd4);
    chk("pulse_sum",  64'(bus8.sum),  64'h8F);
    chk("pulse_ovf",  64'(bus8.ovf),  64'd1);
    tick();
    chk("pulse_not_queued", 64'(bus8.dbg_state), 64'(IDLE));

    // Reset in the middle of RUN: outputs cleared, aborted op never finishes.
    start8(MODE_ADD, 8'h12, 8'h34);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_busy", 64'(bus8.busy), 64'd0);
    chk("mrst_done", 64'(bus8.done), 64'd0);
    chk("mrst_sum",  64'(bus8.sum),  64'd0);
    chk("mrst_cout", 64'(bus8.cout), 64'd0);
    chk("mrst_ovf",  64'(bus8.ovf),  64'd0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus8.done) done_seen++;
    end
    chk("mrst_no_done", 64'(done_seen), 64'd0);
    start8(MODE_ADD, 8'h01, 8'h01);
    wait_done(8, 64, cyc, bcnt, both);
    chk("mrst_after_latency", 64'(cyc), 64'd8);
    chk("mrst_after_sum", 64'(bus8.sum), 64'h02);
    tick();

    // WIDTH=1: 1+1 -> sum 0, carry 1, ovf = cin(0) ^ cout(1).
    bus1.sub   = MODE_ADD;
    bus1.a_in  = 1'b1;
    bus1.b_in  = 1'b1;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    wait_done(1, 16, cyc, bcnt, both);
    chk("w1_latency", 64'(cyc), 64'd1);
    chk("w1_sum",  64'(bus1.sum),  64'd0);
    chk("w1_cout", 64'(bus1.cout), 64'd1);
    chk("w1_ovf",  64'(bus1.ovf),  64'd1);
    tick();
    chk("w1_done_pulse", 64'(bus1.done), 64'd0);

    // WIDTH=32: all-ones + 1 wraps to zero with carry out.
    bus32.sub   = MODE_ADD;
    bus32.a_in  = 32'hFFFF_FFFF;
    bus32.b_in  = 32'h0000_0001;
    bus32.start = 1'b1;
    tick();
    bus32.start = 1'b0;
    wait_done(32, 100, cyc, bcnt, both);
    chk("w32_latency", 64'(cyc), 64'd32);
    chk("w32_sum",  64'(bus32.sum),  64'd0);
    chk("w32_cout", 64'(bus32.cout), 64'd1);
    chk("w32_ovf",  64'(bus32.ovf),  64'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

- Parametrised, sequential successor to the single-bit combinational adder cell.
- Adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, through a single full-adder cell and a registered carry.
- Reports sum, carry-out and signed overflow with a start/busy/done handshake.
- Sits behind the Tiny Tapeout wrapper pins as a small arithmetic unit; trades latency for a one-cell datapath.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  mode, captured with start: 0 = a+b, 1 = a−b (two's complement, b inverted, carry-in 1).
- a_in  in  WIDTH  operand A, captured with start.
- b_in  in  WIDTH  operand B, captured with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- sum  out  WIDTH  result, low WIDTH bits.
- cout  out  1  final carry. For sub, 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → capture a_in, b_in, sub into shift registers.
  - Carry register := sub; bit counter := 0; go to RUN.
  - start=0 → stay.
- RUN, each cycle:
  - Full-adder cell takes a_sh[0], b_sh[0]^sub_q and carry_q.
  - Sum bit shifts into the MSB of the result shift register; a_sh and b_sh shift right.
  - carry_q := cell carry-out; counter increments.
  - On the cycle with counter = WIDTH−1:
    - Copy the completed result register to sum.
    - cout := cell carry-out; ovf := carry_q ^ cell carry-out.
    - Go to DONE.
- DONE:
  - done=1, busy=0.
  - start=1 → accept a new operation exactly as in IDLE (back-to-back).
  - Otherwise go to IDLE.
- start in RUN: ignored, no queueing; in-flight operands are unaffected.
- sum, cout and ovf change only on the completion edge and hold until the next completion. Partial shift contents never reach the outputs.
- WIDTH=1:
  - RUN lasts one cycle.
  - ovf = carry-in ^ carry-out of the single cell.
- Reset (rst_n=0 at a rising edge), any state including mid-RUN:
  - State → IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Shift registers, counter and carry cleared.
  - The aborted operation produces no done.

## Timing
- Edge E0: start accepted. busy=1 from after E0.
- RUN occupies WIDTH cycles (edges E1..E_WIDTH).
- Completion edge E_WIDTH:
  - Outputs update; done=1 and busy=0 in the following cycle.
  - Latency start→done = WIDTH cycles.
- Throughput with start held high: one result every WIDTH+1 cycles (start accepted in DONE).
- busy and done are never high together.
- After reset release: busy=0, done=0 until an operation completes.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package bit_serial_pkg holds:
  - State typedef (IDLE, RUN, DONE) and its encoding.
  - Counter width, $clog2(WIDTH) with a minimum of 1.
  - Mode constants MODE_ADD=0, MODE_SUB=1.
- Sub-module full_adder_cell:
  - Combinational 1-bit full adder: inputs a, b, cin; outputs s = a^b^cin, co = majority.
  - Instantiated once.
- Top module holds the FSM, the shift registers, the carry register and the output registers.

## Test plan
WIDTH=8 unless noted.
- add 0x3A+0x55 → sum=0x8F, cout=0, ovf=1. done exactly 8 cycles after the start edge; busy high for those 8 cycles.
- add 0xFF+0x01 → sum=0x00, cout=1, ovf=0. sub 0x80−0x01 → sum=0x7F, cout=1, ovf=1.
- sub 0x10−0x20 → sum=0xF0, cout=0, ovf=0. Then start held high continuously: the next result arrives 9 cycles after the previous done.
- Start pulsed mid-RUN with different operands → ignored; original result appears; outputs unchanged between completions.
- rst_n low for one edge mid-RUN → all outputs 0 next cycle, no done. A new add 0x01+0x01 then completes with sum=0x02.
- WIDTH=1: 1+1 → sum=0, cout=1, ovf=1, done 1 cycle after start. WIDTH=32: 0xFFFFFFFF+1 → sum=0, cout=1.
